// File: rtl/rom_arb.sv
// Two-requester round-robin arbiter in front of a shared combinational-read ROM.
// One transaction in flight: a request is granted in IDLE, its data is held in RESP until the owner takes it.
module rom_arb #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic [AW-1:0] m0_req_addr,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rsp_data,

  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic [AW-1:0] m1_req_addr,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rsp_data,

  output logic [AW-1:0] rom_raddr,
  input  logic [DW-1:0] rom_rdata
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t        r_state;
  logic          r_last_grant;   // 0 = m0, 1 = m1
  logic          r_owner;
  logic          r_m0_rsp_valid;
  logic          r_m1_rsp_valid;
  logic [DW-1:0] r_rsp_data;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_rsp_done;

  // Grants are gated by rst so nothing can be accepted during a reset cycle.
  assign w_idle     = !rst && (r_state == S_IDLE);
  assign w_gnt0     = w_idle && m0_req_valid && (!m1_req_valid || r_last_grant);
  assign w_gnt1     = w_idle && m1_req_valid && !w_gnt0;
  assign w_rsp_done = r_owner ? m1_rsp_ready : m0_rsp_ready;

  assign m0_req_ready = w_gnt0;
  assign m1_req_ready = w_gnt1;

  // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    rom_raddr = '0;
    if (w_gnt0)      rom_raddr = m0_req_addr;
    else if (w_gnt1) rom_raddr = m1_req_addr;
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_last_grant   <= 1'b1;
      r_owner        <= 1'b0;
      r_m0_rsp_valid <= 1'b0;
      r_m1_rsp_valid <= 1'b0;
      r_rsp_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_rsp_data     <= rom_rdata;
            r_owner        <= w_gnt1;
            r_last_grant   <= w_gnt1;
            r_m0_rsp_valid <= w_gnt0;
            r_m1_rsp_valid <= w_gnt1;
            r_state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_done) begin
            r_m0_rsp_valid <= 1'b0;
            r_m1_rsp_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_rsp_valid = r_m0_rsp_valid;
  assign m1_rsp_valid = r_m1_rsp_valid;
  assign m0_rsp_data  = r_rsp_data;
  assign m1_rsp_data  = r_rsp_data;

endmodule

// File: doc/rom_arb.md
ROM_ARB -- requirements
Module: rom_arb

Interface
- REQ-001 The module SHALL have parameter AW, default 10, meaning the ROM word-address width.
- REQ-002 The module SHALL have parameter DW, default 32, meaning the ROM data width.
- REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
- REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005 The module SHALL have port m0_req_valid, input, 1 bit: requester 0 read request valid.
- REQ-006 The module SHALL have port m0_req_ready, output, 1 bit: requester 0 request accepted this cycle when high together with valid.
- REQ-007 The module SHALL have port m0_req_addr, input, AW bits: requester 0 word address.
- REQ-008 The module SHALL have port m0_rsp_valid, output, 1 bit: requester 0 response data valid.
- REQ-009 The module SHALL have port m0_rsp_ready, input, 1 bit: requester 0 accepts the response.
- REQ-010 The module SHALL have port m0_rsp_data, output, DW bits: requester 0 read data.
- REQ-011 The module SHALL have ports m1_req_valid, m1_req_ready, m1_req_addr, m1_rsp_valid, m1_rsp_ready and m1_rsp_data, identical to REQ-005..REQ-010 but for requester 1.
- REQ-012 The module SHALL have port rom_raddr, output, AW bits: address driven to the shared combinational-read ROM.
- REQ-013 The module SHALL have port rom_rdata, input, DW bits: ROM read data, combinationally valid in the same cycle as rom_raddr.

Function
- REQ-014 The module SHALL implement a two-state FSM, IDLE and RESP, with exactly one outstanding transaction at a time.
- REQ-015 In IDLE, the module SHALL grant at most one requester per cycle; mX_req_ready SHALL be high only for the granted port, combinationally from the valids.
- REQ-016 Arbitration SHALL be round-robin: if only one port is valid, that port is granted; if both are valid, the port that is not last_grant is granted.
- REQ-017 last_grant SHALL update to the accepted port on each accept, and SHALL be unchanged otherwise.
- REQ-018 In IDLE, rom_raddr SHALL equal the granted port's req_addr; with no grant, and in RESP, rom_raddr SHALL be 0.
- REQ-019 On accept (valid & ready), the module SHALL capture rom_rdata into a DW-bit response register, record the owner, and move to RESP on the next edge.
- REQ-020 In RESP, the owner's rsp_valid SHALL be 1 and its rsp_data SHALL equal the captured value, held stable until rsp_ready is sampled high.
- REQ-021 In RESP, the other port's rsp_valid SHALL be 0, and both req_ready outputs SHALL be 0.
- REQ-022 In RESP, when the owner's rsp_ready is high the FSM SHALL return to IDLE at the next edge; a new request SHALL NOT be accepted in that same cycle.
- REQ-023 Best-case throughput SHALL be one read per 2 cycles; request-to-rsp_valid latency SHALL be 1 cycle.
- REQ-024 A requester SHALL be allowed to change or drop its req_valid or req_addr while not granted, without effect on the module.
- REQ-025 rsp_data of a non-owner port SHALL be the captured register value; consumers SHALL qualify it with rsp_valid.

Reset
- REQ-026 While rst is high at a clock edge, the FSM SHALL enter IDLE and last_grant SHALL become 1, so that m0 wins the first contention.
- REQ-027 While rst is high at a clock edge, the response register SHALL clear to 0.
- REQ-028 After a reset edge, all rsp_valid outputs SHALL be 0.
- REQ-029 While rst is high, req_ready SHALL be forced to 0 and no accept SHALL occur.
- REQ-030 A reset asserted in RESP SHALL drop the pending response (rsp_valid 0 after the edge) without delivering it.

Verification
- REQ-031 The bench SHALL cover single read: m0 valid with addr 0x005, ROM[5]=0xDEADBEEF -> m0_req_ready=1 in the same cycle; next cycle m0_rsp_valid=1 and m0_rsp_data=0xDEADBEEF; with m0_rsp_ready=1, IDLE at the following edge.
- REQ-032 The bench SHALL cover contention after reset: both valid (m0 addr 1, m1 addr 2) -> m0 served first, then m1, then m0 again if both remain valid.
- REQ-033 The bench SHALL cover backpressure: m1 response with m1_rsp_ready=0 for 5 cycles -> rsp_valid and data stable for all 5 cycles, both req_ready 0 and rom_raddr 0 throughout.
- REQ-034 The bench SHALL cover address boundary: addr 0x3FF with AW=10 -> ROM[1023] returned, with no wrap or truncation error.
- REQ-035 The bench SHALL cover reset mid-operation: rst pulsed in RESP -> rsp_valid 0 after the edge, data register 0, and m0 wins the next contention.
- REQ-036 The bench SHALL cover a drop before grant: m1 valid for 1 cycle while in RESP serving m0, then deasserted -> m1 never accepted and no m1 response produced.
